// File: rtl/partition_engine.sv
`default_nettype none
// ============================================================================
// Module   : partition_engine
// Purpose  : Lomuto partition of array sub-range [lo_ind, hi_ind] around the
//            pivot at hi_ind, one compare/swap per clock, start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module partition_engine #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = (DEPTH > 1 ? $clog2(DEPTH) : 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    descend,
  input  logic [DEPTH*DATA_W-1:0] array_in,
  input  logic [IDX_W-1:0]        lo_ind,
  input  logic [IDX_W-1:0]        hi_ind,
  output logic [DEPTH*DATA_W-1:0] array_out,
  output logic [IDX_W-1:0]        pivot_ind,
  output logic [DATA_W-1:0]       pivot_val,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Working buffer and scan bookkeeping
  logic [DATA_W-1:0] elem_q [DEPTH];
  logic [DATA_W-1:0] elem_d [DEPTH];
  logic [DATA_W-1:0] in_elem [DEPTH];
  logic [IDX_W-1:0]  i_q, i_d;
  logic [IDX_W-1:0]  j_q, j_d;
  logic [IDX_W-1:0]  hi_q, hi_d;
  logic [DATA_W-1:0] pivot_q, pivot_d;
  logic              desc_q, desc_d;
  // An invalid range still answers one cycle after start, without going busy
  logic              err_pend_q, err_pend_d;

  // Registered outputs
  logic [DEPTH*DATA_W-1:0] array_out_q, array_out_d;
  logic [IDX_W-1:0]        pivot_ind_q, pivot_ind_d;
  logic [DATA_W-1:0]       pivot_val_q, pivot_val_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic             range_valid;
  logic             take;
  logic             load_out;
  logic [IDX_W-1:0] j_next;

  // Unpack the input array and qualify the requested range
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      in_elem[k] = array_in[k*DATA_W +: DATA_W];
    end
    range_valid = (lo_ind <= hi_ind) && (32'(hi_ind) < DEPTH);
  end

  // Next-state, datapath update and output staging
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    i_d         = i_q;
    j_d         = j_q;
    hi_d        = hi_q;
    pivot_d     = pivot_q;
    desc_d      = desc_q;
    err_pend_d  = 1'b0;
    array_out_d = array_out_q;
    pivot_ind_d = pivot_ind_q;
    pivot_val_d = pivot_val_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    load_out    = 1'b0;
    j_next      = j_q + IDX_W'(1);
    take        = desc_q ? (elem_q[j_q] >= pivot_q) : (elem_q[j_q] <= pivot_q);

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (err_pend_q) begin
          // Report the rejected request; buffer holds the untouched input
          done_d      = 1'b1;
          error_d     = 1'b1;
          load_out    = 1'b1;
          pivot_ind_d = '0;
          pivot_val_d = '0;
        end else if (start) begin
          elem_d = in_elem;
          if (range_valid) begin
            pivot_d = in_elem[hi_ind];
            i_d     = lo_ind;
            j_d     = lo_ind;
            hi_d    = hi_ind;
            desc_d  = descend;
            busy_d  = 1'b1;
            state_d = (lo_ind < hi_ind) ? SCAN : FINAL;
          end else begin
            err_pend_d = 1'b1;
          end
        end
      end

      SCAN: begin
        // Compare and swap complete in one cycle; i==j degenerates to a no-op
        if (take) begin
          elem_d[i_q] = elem_q[j_q];
          elem_d[j_q] = elem_q[i_q];
          i_d         = i_q + IDX_W'(1);
        end
        j_d = j_next;
        if (j_next == hi_q) begin
          state_d = FINAL;
        end
      end

      FINAL: begin
        // Drop the pivot into its final slot and publish the result
        elem_d[i_q]  = elem_q[hi_q];
        elem_d[hi_q] = elem_q[i_q];
        load_out     = 1'b1;
        pivot_ind_d  = i_q;
        pivot_val_d  = pivot_q;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (load_out) begin
      for (int k = 0; k < DEPTH; k++) begin
        array_out_d[k*DATA_W +: DATA_W] = elem_d[k];
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int k = 0; k < DEPTH; k++) begin
        elem_q[k] <= '0;
      end
      i_q         <= '0;
      j_q         <= '0;
      hi_q        <= '0;
      pivot_q     <= '0;
      desc_q      <= 1'b0;
      err_pend_q  <= 1'b0;
      array_out_q <= '0;
      pivot_ind_q <= '0;
      pivot_val_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      i_q         <= i_d;
      j_q         <= j_d;
      hi_q        <= hi_d;
      pivot_q     <= pivot_d;
      desc_q      <= desc_d;
      err_pend_q  <= err_pend_d;
      array_out_q <= array_out_d;
      pivot_ind_q <= pivot_ind_d;
      pivot_val_q <= pivot_val_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign array_out = array_out_q;
  assign pivot_ind = pivot_ind_q;
  assign pivot_val = pivot_val_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_partition_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_partition_engine
// Purpose  : Scoreboard bench for partition_engine: directed cases plus random
//            ranges checked against a behavioural Lomuto model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_partition_engine;
  localparam int DW = 4;
  localparam int DP = 4;
  localparam int IW = 2;
  localparam int AW = DW * DP;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          descend;
  logic [AW-1:0] array_in;
  logic [IW-1:0] lo_ind;
  logic [IW-1:0] hi_ind;
  logic [AW-1:0] array_out;
  logic [IW-1:0] pivot_ind;
  logic [DW-1:0] pivot_val;
  logic          busy;
  logic          done;
  logic          error;

  partition_engine #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .descend  (descend),
    .array_in (array_in),
    .lo_ind   (lo_ind),
    .hi_ind   (hi_ind),
    .array_out(array_out),
    .pivot_ind(pivot_ind),
    .pivot_val(pivot_val),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] arr;
    logic [IW-1:0] pidx;
    logic [DW-1:0] pval;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the partition rules applied to a plain integer array
  function automatic exp_t model(input logic [AW-1:0] arr, input int lo, input int hi, input bit desc);
    int   a[DP];
    int   p, s, t;
    exp_t e;
    for (int k = 0; k < DP; k++) a[k] = int'(arr[k*DW +: DW]);
    e.arr  = arr;
    e.pidx = '0;
    e.pval = '0;
    e.err  = 1'b0;
    if (!(lo <= hi && hi < DP)) begin
      e.err = 1'b1;
      return e;
    end
    p = a[hi];
    s = lo;
    for (int j = lo; j < hi; j++) begin
      if (desc ? (a[j] >= p) : (a[j] <= p)) begin
        t = a[s]; a[s] = a[j]; a[j] = t;
        s++;
      end
    end
    t = a[s]; a[s] = a[hi]; a[hi] = t;
    for (int k = 0; k < DP; k++) e.arr[k*DW +: DW] = DW'(a[k]);
    e.pidx = IW'(s);
    e.pval = DW'(p);
    return e;
  endfunction

  // Monitor: every done pops one expected result
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        e = sb.pop_front();
        check("array_out", 32'(array_out), 32'(e.arr));
        check("pivot_ind", 32'(pivot_ind), 32'(e.pidx));
        check("pivot_val", 32'(pivot_val), 32'(e.pval));
        check("error",     32'(error),     32'(e.err));
      end
    end
  end

  task automatic check_all_zero();
    check("rst_array_out", 32'(array_out), 32'h0);
    check("rst_pivot_ind", 32'(pivot_ind), 32'h0);
    check("rst_pivot_val", 32'(pivot_val), 32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_done",      32'(done),      32'h0);
    check("rst_error",     32'(error),     32'h0);
  endtask

  task automatic do_start(input logic [AW-1:0] arr, input int lo, input int hi, input bit desc, input exp_t e);
    array_in = arr;
    lo_ind   = IW'(lo);
    hi_ind   = IW'(hi);
    descend  = desc;
    start    = 1'b1;
    sb.push_back(e);
  endtask

  // One request; returns in the done cycle so the next start is back-to-back
  task automatic run(input logic [AW-1:0] arr, input int lo, input int hi, input bit desc,
                     input bit use_model, input exp_t given, input bit glitch);
    exp_t e;
    int   lat, bc, explat;
    e = use_model ? model(arr, lo, hi, desc) : given;
    do_start(arr, lo, hi, desc, e);
    @(posedge clock); #1;
    start = 1'b0;
    if (glitch) begin
      start    = 1'b1;
      array_in = AW'($urandom);
      lo_ind   = '0;
      hi_ind   = 2'd3;
    end
    lat = 0;
    bc  = 0;
    for (int k = 0; k < 40 && done !== 1'b1; k++) begin
      if (busy === 1'b1) bc++;
      @(posedge clock); #1;
      start = 1'b0;
      lat++;
    end
    explat = e.err ? 1 : (hi - lo + 1);
    check("done_seen",    32'(done), 32'h1);
    check("latency",      32'(lat),  32'(explat));
    check("busy_cycles",  32'(bc),   e.err ? 32'h0 : 32'(explat));
    check("busy_at_done", 32'(busy), 32'h0);
  endtask

  initial begin : main
    exp_t e;
    int   nd;
    reset    = 1'b1;
    start    = 1'b0;
    descend  = 1'b0;
    array_in = '0;
    lo_ind   = '0;
    hi_ind   = '0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero();
    reset = 1'b0;
    @(posedge clock); #1;

    // Directed cases with hand-derived results
    e = '{16'h3421, 2'd1, 4'd2, 1'b0};  run(16'h2413, 0, 3, 1'b0, 1'b0, e, 1'b0);
    e = '{16'h1243, 2'd2, 4'd2, 1'b0};  run(16'h2413, 0, 3, 1'b1, 1'b0, e, 1'b0);
    e = '{16'h5555, 2'd3, 4'd5, 1'b0};  run(16'h5555, 0, 3, 1'b0, 1'b0, e, 1'b0);
    e = '{16'h2413, 2'd2, 4'd4, 1'b0};  run(16'h2413, 2, 2, 1'b0, 1'b0, e, 1'b0);
    e = '{16'h2413, 2'd0, 4'd0, 1'b1};  run(16'h2413, 3, 1, 1'b0, 1'b0, e, 1'b0);
    e = '{16'h2413, 2'd2, 4'd4, 1'b0};  run(16'h2413, 1, 2, 1'b0, 1'b0, e, 1'b1);
    e = '{16'h3421, 2'd1, 4'd2, 1'b0};  run(16'h2413, 0, 3, 1'b0, 1'b0, e, 1'b0);

    // Reset two cycles into a full-range run
    do_start(16'h2413, 0, 3, 1'b0, e);
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check_all_zero();
    sb.delete();
    reset = 1'b0;
    nd = 0;
    repeat (8) begin
      @(posedge clock); #1;
      if (done === 1'b1) nd++;
    end
    check("no_done_after_reset", 32'(nd), 32'h0);
    e = '{16'h3421, 2'd1, 4'd2, 1'b0};  run(16'h2413, 0, 3, 1'b0, 1'b0, e, 1'b0);

    // Random ranges, orders and contents (includes lo>hi rejections)
    for (int n = 0; n < 80; n++) begin
      run(AW'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          bit'($urandom_range(0, 1)), 1'b1, e, bit'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clock);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
